// File: rtl/buffer_reporter.sv
// buffer_reporter: read-side companion to the sample buffer.
// On a start request it snapshots the buffer statistics, sweeps every buffer
// address and streams one framed byte sequence over a valid/ready link:
// header, count, samples, max, min, avg, then an XOR checksum.
module buffer_reporter #(
    parameter int         DEPTH      = 8,
    parameter int         ADDR_WIDTH = 3,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    input  logic [7:0]            stat_max,
    input  logic [7:0]            stat_min,
    input  logic [7:0]            stat_avg,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_CNT,
        S_FETCH,
        S_SAMPLE,
        S_MAX,
        S_MIN,
        S_AVG,
        S_CSUM
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [7:0]            COUNT_BYTE = 8'(DEPTH);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
    logic [7:0]              csum, csum_nxt;
    logic [7:0]              snap_max, snap_max_nxt;
    logic [7:0]              snap_min, snap_min_nxt;
    logic [7:0]              snap_avg, snap_avg_nxt;
    logic [ADDR_WIDTH-1:0]   rd_addr_nxt;
    logic [7:0]              tx_data_nxt;
    logic                    tx_valid_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    handshake;

    assign handshake = tx_valid && tx_ready;

    // Next-state, sample index, checksum and statistics snapshot.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        csum_nxt     = csum;
        snap_max_nxt = snap_max;
        snap_min_nxt = snap_min;
        snap_avg_nxt = snap_avg;
        done_nxt     = 1'b0;

        if (handshake) begin
            csum_nxt = csum ^ tx_data;
        end

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    snap_max_nxt = stat_max;
                    snap_min_nxt = stat_min;
                    snap_avg_nxt = stat_avg;
                    idx_nxt      = '0;
                    csum_nxt     = 8'h00;
                    state_nxt    = S_HDR;
                end
            end
            S_HDR: begin
                if (handshake) state_nxt = S_CNT;
            end
            S_CNT: begin
                if (handshake) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_MAX;
                    end else begin
                        idx_nxt   = idx + ADDR_WIDTH'(1);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_MAX: begin
                if (handshake) state_nxt = S_MIN;
            end
            S_MIN: begin
                if (handshake) state_nxt = S_AVG;
            end
            S_AVG: begin
                if (handshake) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (handshake) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output bytes are loaded only on entry to a state, so they hold through back-pressure.
    always_comb begin
        tx_data_nxt  = tx_data;
        rd_addr_nxt  = rd_addr;
        tx_valid_nxt = 1'b0;
        busy_nxt     = (state_nxt != S_IDLE);

        unique case (state_nxt)
            S_HDR, S_CNT, S_SAMPLE, S_MAX, S_MIN, S_AVG, S_CSUM: tx_valid_nxt = 1'b1;
            default:                                             tx_valid_nxt = 1'b0;
        endcase

        if (state_nxt != state) begin
            unique case (state_nxt)
                S_HDR:    tx_data_nxt = HEADER;
                S_CNT:    tx_data_nxt = COUNT_BYTE;
                S_FETCH:  rd_addr_nxt = idx_nxt;
                S_SAMPLE: tx_data_nxt = rd_data;
                S_MAX:    tx_data_nxt = snap_max;
                S_MIN:    tx_data_nxt = snap_min;
                S_AVG:    tx_data_nxt = snap_avg;
                S_CSUM:   tx_data_nxt = csum_nxt;
                default:  tx_data_nxt = tx_data;
            endcase
        end
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            csum     <= 8'h00;
            snap_max <= 8'h00;
            snap_min <= 8'h00;
            snap_avg <= 8'h00;
            rd_addr  <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            csum     <= csum_nxt;
            snap_max <= snap_max_nxt;
            snap_min <= snap_min_nxt;
            snap_avg <= snap_avg_nxt;
            rd_addr  <= rd_addr_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule
